// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Generates the pipeline register enables and clears and the PC enable from
// Tuse/Tnew data hazards, HI/LO unit occupancy and eret-vs-mtc0 EPC ordering.
// Also broadcasts the exception flush and counts stall cycles.
//
// MD FSM states
//   state   | meaning
//   MD_IDLE | HI/LO unit free; a mult/div start in E may load the counter
//   MD_BUSY | HI/LO unit computing; md_cnt holds the remaining busy cycles
module pipe_hazard_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_tuseRs,
    input  logic [1:0]  D_tuseRt,
    input  logic [4:0]  E_wa,
    input  logic [1:0]  E_tnew,
    input  logic [4:0]  M_wa,
    input  logic [1:0]  M_tnew,
    input  logic        D_isMD,
    input  logic        E_mdStart,
    input  logic        E_mdIsDiv,
    input  logic        D_eret,
    input  logic        E_mtcEPC,
    input  logic        M_mtcEPC,
    input  logic        Req,
    output logic        pcEn,
    output logic        FD_en,
    output logic        DE_en,
    output logic        EM_en,
    output logic        MW_en,
    output logic        FD_clr,
    output logic        DE_clr,
    output logic        EM_clr,
    output logic        MW_clr,
    output logic        flushReq,
    output logic        mdBusy,
    output logic [31:0] stallCnt
);

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // Counter holds busy cycles remaining after the start cycle, hence the -1.
    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC - 1);

    md_state_t  md_state, md_state_nxt;
    logic [3:0] md_cnt, md_cnt_nxt;
    logic [3:0] md_load;
    logic       md_start;
    logic       haz_rs, haz_rt;
    logic       stall_md, stall_eret;
    logic       stall;

    // An exception in the start cycle kills the mult/div, so it never loads.
    assign md_start = (md_state == MD_IDLE) & E_mdStart & ~Req;
    assign md_load  = E_mdIsDiv ? DIV_LOAD : MULT_LOAD;
    assign mdBusy   = md_start | (md_state == MD_BUSY);

    assign haz_rs = (D_rs != 5'd0) &
                    (((E_wa == D_rs) & (E_tnew > D_tuseRs)) |
                     ((M_wa == D_rs) & (M_tnew > D_tuseRs)));
    assign haz_rt = (D_rt != 5'd0) &
                    (((E_wa == D_rt) & (E_tnew > D_tuseRt)) |
                     ((M_wa == D_rt) & (M_tnew > D_tuseRt)));

    assign stall_md   = D_isMD & mdBusy;
    assign stall_eret = D_eret & (E_mtcEPC | M_mtcEPC);
    assign stall      = (haz_rs | haz_rt | stall_md | stall_eret) & ~Req;

    // MD state and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_state <= MD_IDLE;
            md_cnt   <= 4'd0;
        end else begin
            md_state <= md_state_nxt;
            md_cnt   <= md_cnt_nxt;
        end
    end

    // MD next state: load on start, count down while busy. A committed op keeps
    // running through an exception, so Req does not touch the BUSY path.
    always_comb begin
        md_state_nxt = md_state;
        md_cnt_nxt   = md_cnt;
        unique case (md_state)
            MD_IDLE: begin
                if (md_start) begin
                    md_cnt_nxt   = md_load;
                    md_state_nxt = (md_load != 4'd0) ? MD_BUSY : MD_IDLE;
                end
            end
            MD_BUSY: begin
                if (md_cnt <= 4'd1) begin
                    md_cnt_nxt   = 4'd0;
                    md_state_nxt = MD_IDLE;
                end else begin
                    md_cnt_nxt   = md_cnt - 4'd1;
                end
            end
            default: begin
                md_cnt_nxt   = 4'd0;
                md_state_nxt = MD_IDLE;
            end
        endcase
    end

    // Pipeline control: exception flush beats stall, stall freezes F/D and bubbles D/E.
    always_comb begin
        pcEn     = 1'b1;
        FD_en    = 1'b1;
        DE_en    = 1'b1;
        EM_en    = 1'b1;
        MW_en    = 1'b1;
        FD_clr   = 1'b0;
        DE_clr   = 1'b0;
        EM_clr   = 1'b0;
        MW_clr   = 1'b0;
        flushReq = 1'b0;
        if (Req) begin
            flushReq = 1'b1;
        end else if (stall) begin
            pcEn   = 1'b0;
            FD_en  = 1'b0;
            DE_clr = 1'b1;
        end
    end

    // Stall cycle counter, free-running wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCnt <= 32'd0;
        end else if (stall) begin
            stallCnt <= stallCnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed table vectors plus multi-cycle sequences.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_rs, D_rt, E_wa, M_wa;
    logic [1:0]  D_tuseRs, D_tuseRt, E_tnew, M_tnew;
    logic        D_isMD, E_mdStart, E_mdIsDiv, D_eret, E_mtcEPC, M_mtcEPC, Req;
    logic        pcEn, FD_en, DE_en, EM_en, MW_en;
    logic        FD_clr, DE_clr, EM_clr, MW_clr, flushReq, mdBusy;
    logic [31:0] stallCnt;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_cnt;

    pipe_hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_tuseRs(D_tuseRs), .D_tuseRt(D_tuseRt),
        .E_wa(E_wa), .E_tnew(E_tnew), .M_wa(M_wa), .M_tnew(M_tnew),
        .D_isMD(D_isMD), .E_mdStart(E_mdStart), .E_mdIsDiv(E_mdIsDiv),
        .D_eret(D_eret), .E_mtcEPC(E_mtcEPC), .M_mtcEPC(M_mtcEPC), .Req(Req),
        .pcEn(pcEn), .FD_en(FD_en), .DE_en(DE_en), .EM_en(EM_en), .MW_en(MW_en),
        .FD_clr(FD_clr), .DE_clr(DE_clr), .EM_clr(EM_clr), .MW_clr(MW_clr),
        .flushReq(flushReq), .mdBusy(mdBusy), .stallCnt(stallCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs;  logic [4:0] rt;
        logic [1:0] tu_rs; logic [1:0] tu_rt;
        logic [4:0] e_wa; logic [1:0] e_tn;
        logic [4:0] m_wa; logic [1:0] m_tn;
        logic md; logic eret; logic e_mtc; logic m_mtc; logic req;
        logic x_stall; logic x_flush;
    } vec_t;

    vec_t tv[12];

    // {pcEn,FD_en,DE_en,EM_en,MW_en,FD_clr,DE_clr,EM_clr,MW_clr,flushReq}
    localparam logic [9:0] CTRL_IDLE  = 10'b11111_0000_0;
    localparam logic [9:0] CTRL_STALL = 10'b00111_0100_0;
    localparam logic [9:0] CTRL_FLUSH = 10'b11111_0000_1;

    function automatic logic [9:0] ctrl_now();
        return {pcEn, FD_en, DE_en, EM_en, MW_en, FD_clr, DE_clr, EM_clr, MW_clr, flushReq};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        D_rs = 0; D_rt = 0; D_tuseRs = 2'd3; D_tuseRt = 2'd3;
        E_wa = 0; E_tnew = 0; M_wa = 0; M_tnew = 0;
        D_isMD = 0; E_mdStart = 0; E_mdIsDiv = 0;
        D_eret = 0; E_mtcEPC = 0; M_mtcEPC = 0; Req = 0;
    endtask

    initial begin
        int busy_n, stall_n;
        logic [31:0] cnt0;

        //          rs rt tuR tuT ewa etn mwa mtn md er em mm rq  stall flush
        tv[0]  = '{5'd1, 5'd0, 2'd0, 2'd3, 5'd1, 2'd2, 5'd0, 2'd0, 0,0,0,0,0, 1,0};
        tv[1]  = '{5'd0, 5'd0, 2'd0, 2'd3, 5'd0, 2'd2, 5'd0, 2'd0, 0,0,0,0,0, 0,0};
        tv[2]  = '{5'd1, 5'd0, 2'd2, 2'd3, 5'd1, 2'd2, 5'd0, 2'd0, 0,0,0,0,0, 0,0};
        tv[3]  = '{5'd0, 5'd5, 2'd3, 2'd1, 5'd0, 2'd0, 5'd5, 2'd2, 0,0,0,0,0, 1,0};
        tv[4]  = '{5'd0, 5'd5, 2'd3, 2'd3, 5'd0, 2'd0, 5'd5, 2'd2, 0,0,0,0,0, 0,0};
        tv[5]  = '{5'd3, 5'd0, 2'd0, 2'd3, 5'd4, 2'd2, 5'd0, 2'd0, 0,0,0,0,0, 0,0};
        tv[6]  = '{5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, 0,1,0,1,0, 1,0};
        tv[7]  = '{5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, 0,1,1,0,1, 0,1};
        tv[8]  = '{5'd1, 5'd0, 2'd0, 2'd3, 5'd1, 2'd2, 5'd0, 2'd0, 0,0,0,0,1, 0,1};
        tv[9]  = '{5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, 0,1,0,0,0, 0,0};
        tv[10] = '{5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, 1,0,0,0,0, 0,0};
        tv[11] = '{5'd7, 5'd0, 2'd1, 2'd3, 5'd7, 2'd1, 5'd7, 2'd2, 0,0,0,0,0, 1,0};

        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_stallcnt", stallCnt, 32'd0);
        check("reset_mdbusy", {31'd0, mdBusy}, 32'd0);
        check("reset_ctrl", {22'd0, ctrl_now()}, {22'd0, CTRL_IDLE});
        exp_cnt = 0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            D_rs = tv[i].rs; D_rt = tv[i].rt; D_tuseRs = tv[i].tu_rs; D_tuseRt = tv[i].tu_rt;
            E_wa = tv[i].e_wa; E_tnew = tv[i].e_tn; M_wa = tv[i].m_wa; M_tnew = tv[i].m_tn;
            D_isMD = tv[i].md; D_eret = tv[i].eret; E_mtcEPC = tv[i].e_mtc;
            M_mtcEPC = tv[i].m_mtc; Req = tv[i].req;
            #1;
            check($sformatf("vec%0d_ctrl", i), {22'd0, ctrl_now()},
                  {22'd0, tv[i].x_flush ? CTRL_FLUSH : (tv[i].x_stall ? CTRL_STALL : CTRL_IDLE)});
            if (tv[i].x_stall) exp_cnt = exp_cnt + 1;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_stallcnt", i), stallCnt, exp_cnt);
        end

        // div: busy 10 cycles including start, D_isMD afterwards stalls 9
        @(negedge clk);
        idle_inputs();
        E_mdStart = 1; E_mdIsDiv = 1;
        #1;
        check("div_start_busy", {31'd0, mdBusy}, 32'd1);
        check("div_start_nostall", {31'd0, pcEn}, 32'd1);
        cnt0 = stallCnt;
        busy_n = 1; stall_n = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            E_mdStart = 0; E_mdIsDiv = 0; D_isMD = 1;
            #1;
            busy_n += int'(mdBusy);
            stall_n += int'(!pcEn);
        end
        check("div_busy_cycles", busy_n, 32'd10);
        check("div_stall_cycles", stall_n, 32'd9);
        check("div_stallcnt_delta", stallCnt - cnt0, 32'd9);

        // Req during start: flushed, counter never loaded
        @(negedge clk);
        idle_inputs();
        E_mdStart = 1; Req = 1; D_isMD = 1;
        #1;
        check("req_start_ctrl", {22'd0, ctrl_now()}, {22'd0, CTRL_FLUSH});
        check("req_start_busy", {31'd0, mdBusy}, 32'd0);
        cnt0 = stallCnt;
        @(negedge clk);
        E_mdStart = 0; Req = 0;
        #1;
        check("req_start_notloaded", {31'd0, mdBusy}, 32'd0);
        check("req_start_nocount", stallCnt, cnt0);

        // mult with Req mid-busy: still busy 5 cycles total
        @(negedge clk);
        idle_inputs();
        E_mdStart = 1;
        #1;
        busy_n = int'(mdBusy);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            E_mdStart = 0;
            Req = (c == 1);
            #1;
            busy_n += int'(mdBusy);
        end
        check("mult_req_mid_busy", busy_n, 32'd5);

        // async reset mid-mult with md_cnt=3
        @(negedge clk);
        idle_inputs();
        E_mdStart = 1;
        @(negedge clk);
        E_mdStart = 0; D_isMD = 1;
        @(negedge clk);
        #1;
        check("mid_mult_stall", {22'd0, ctrl_now()}, {22'd0, CTRL_STALL});
        check("mid_mult_cnt_nonzero", {31'd0, (stallCnt != 0)}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("areset_mdbusy", {31'd0, mdBusy}, 32'd0);
        check("areset_stallcnt", stallCnt, 32'd0);
        check("areset_ctrl", {22'd0, ctrl_now()}, {22'd0, CTRL_IDLE});
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("post_reset_mdbusy", {31'd0, mdBusy}, 32'd0);
        check("post_reset_stallcnt", stallCnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
